// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the iterative divider.
package cpu_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  localparam logic [DIV_WIDTH-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract if it fits.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] r_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] r_sh;
  logic             fits;

  // The partial remainder never needs its MSB here: after k steps it is below 2^k.
  always_comb begin
    r_sh = {r_i[WIDTH-2:0], q_i[WIDTH-1]};
    fits = (r_sh >= d_i);
    r_o  = fits ? (r_sh - d_i) : r_sh;
    q_o  = {q_i[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/div_unit.sv
// Iterative DIV/DIVU unit: sign-magnitude restoring divide with start/busy/done handshake.
module div_unit
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] a_orig_q, a_orig_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] step_r, step_q;
  logic             sa, sb;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_i (r_q),
    .q_i (q_q),
    .d_i (d_q),
    .r_o (step_r),
    .q_o (step_q)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    r_d      = r_q;
    q_d      = q_q;
    d_d      = d_q;
    a_orig_d = a_orig_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    zero_d   = zero_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    dz_d     = dz_q;
    sa       = dividend[WIDTH-1] & is_signed;
    sb       = divisor[WIDTH-1] & is_signed;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Operands are held as magnitudes; signs are reapplied in FIX.
          state_d  = RUN;
          sign_a_d = sa;
          sign_b_d = sb;
          q_d      = sa ? (~dividend + WIDTH'(1)) : dividend;
          d_d      = sb ? (~divisor + WIDTH'(1)) : divisor;
          a_orig_d = dividend;
          zero_d   = (divisor == '0);
          r_d      = '0;
          cnt_d    = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        r_d   = step_r;
        q_d   = step_q;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        state_d = DONE;
        if (zero_q) begin
          quot_d = WIDTH'(DIV0_QUOT);
          rem_d  = a_orig_q;
          dz_d   = 1'b1;
        end else begin
          quot_d = (sign_a_q ^ sign_b_q) ? (~q_q + WIDTH'(1)) : q_q;
          rem_d  = sign_a_q ? (~r_q + WIDTH'(1)) : r_q;
          dz_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN) || (state_d == FIX);
    done_d = (state_q == FIX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      r_q      <= '0;
      q_q      <= '0;
      d_q      <= '0;
      a_orig_q <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      zero_q   <= 1'b0;
      quot_q   <= '0;
      rem_q    <= '0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      r_q      <= r_d;
      q_q      <= q_d;
      d_q      <= d_d;
      a_orig_q <= a_orig_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      zero_q   <= zero_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      dz_q     <= dz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random operands vs. an arithmetic model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int total = 0;
  int bad = 0;

  div_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  // MIPS semantics: truncating divide, remainder carries the dividend's sign.
  task automatic model(input logic s, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r, output logic dz);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      dz = 1'b1;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = 32'(sa / sb);
      r = 32'(sa % sb);
      dz = 1'b0;
    end else begin
      q = a / b;
      r = a % b;
      dz = 1'b0;
    end
  endtask

  // Issues one divide (caller must be in an accepting cycle) and waits for done.
  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic dz,
                         output int lat, output logic busy_first, output logic busy_last);
    start = 1'b1;
    is_signed = s;
    dividend = a;
    divisor = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    is_signed = $urandom_range(0, 1);
    dividend = $urandom;
    divisor = $urandom;
    lat = 0;
    busy_first = busy;
    busy_last = busy;
    while (!done && lat < 100) begin
      busy_last = busy;
      @(posedge clk);
      #1;
      lat++;
    end
    q = quotient;
    r = remainder;
    dz = div_by_zero;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (quotient !== 32'd0) begin bad++; $display("FAIL reset_quot got=%h exp=0", quotient); end
    total++; if (remainder !== 32'd0) begin bad++; $display("FAIL reset_rem got=%h exp=0", remainder); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dz got=%b exp=0", div_by_zero); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_divu_basic();
    logic [31:0] q, r;
    logic dz, bf, bl;
    int lat;
    run_div(1'b0, 32'd100, 32'd7, q, r, dz, lat, bf, bl);
    total++; if (lat !== 33) begin bad++; $display("FAIL basic_latency got=%0d exp=33", lat); end
    total++; if (q !== 32'd14) begin bad++; $display("FAIL basic_quot got=%h exp=%h", q, 32'd14); end
    total++; if (r !== 32'd2) begin bad++; $display("FAIL basic_rem got=%h exp=%h", r, 32'd2); end
    total++; if (dz !== 1'b0) begin bad++; $display("FAIL basic_dz got=%b exp=0", dz); end
    total++; if (bf !== 1'b1) begin bad++; $display("FAIL basic_busy_first got=%b exp=1", bf); end
    total++; if (bl !== 1'b1) begin bad++; $display("FAIL basic_busy_last got=%b exp=1", bl); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done got=%b exp=0", busy); end
    @(posedge clk);
    #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
    total++; if (q !== quotient) begin bad++; $display("FAIL basic_hold got=%h exp=%h", quotient, q); end
  endtask

  task automatic test_directed();
    vec_t v[9];
    logic [31:0] q, r;
    logic dz, bf, bl;
    int lat;
    v[0] = '{1'b1, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0};
    v[1] = '{1'b1, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2,         1'b0};
    v[2] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0};
    v[3] = '{1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0};
    v[4] = '{1'b0, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 32'h1234_5678, 1'b1};
    v[5] = '{1'b0, 32'd9,         32'd3,         32'd3,         32'd0,         1'b0};
    v[6] = '{1'b1, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1};
    v[7] = '{1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1,         32'h7FFF_FFFE, 1'b0};
    v[8] = '{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        32'hFFFF_FFFE, 1'b0};
    for (int i = 0; i < 9; i++) begin
      run_div(v[i].s, v[i].a, v[i].b, q, r, dz, lat, bf, bl);
      total++; if (lat !== 33) begin bad++; $display("FAIL dir%0d_latency got=%0d exp=33", i, lat); end
      total++; if (q !== v[i].q) begin bad++; $display("FAIL dir%0d_quot got=%h exp=%h", i, q, v[i].q); end
      total++; if (r !== v[i].r) begin bad++; $display("FAIL dir%0d_rem got=%h exp=%h", i, r, v[i].r); end
      total++; if (dz !== v[i].dz) begin bad++; $display("FAIL dir%0d_dz got=%b exp=%b", i, dz, v[i].dz); end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, q, r, eq, er;
    logic s, dz, edz, bf, bl;
    int lat;
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 4))
        0: b = $urandom;
        1: b = 32'($urandom_range(1, 255));
        2: b = -32'($urandom_range(1, 255));
        3: b = 32'd0;
        default: b = 32'hFFFF_FFFF;
      endcase
      model(s, a, b, eq, er, edz);
      run_div(s, a, b, q, r, dz, lat, bf, bl);
      total++; if (lat !== 33) begin bad++; $display("FAIL rnd%0d_latency got=%0d exp=33", i, lat); end
      total++; if (q !== eq || r !== er || dz !== edz) begin
        bad++;
        $display("FAIL rnd%0d_result s=%b a=%h b=%h got q=%h r=%h dz=%b exp q=%h r=%h dz=%b",
                 i, s, a, b, q, r, dz, eq, er, edz);
      end
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_start_while_busy();
    logic [31:0] prev_q, prev_r;
    int lat;
    prev_q = quotient;
    prev_r = remainder;
    start = 1'b1;
    is_signed = 1'b0;
    dividend = 32'd1000;
    divisor = 32'd10;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    total++; if (quotient !== prev_q || remainder !== prev_r) begin
      bad++; $display("FAIL midrun_hold got q=%h r=%h exp q=%h r=%h", quotient, remainder, prev_q, prev_r);
    end
    start = 1'b1;
    dividend = 32'd77;
    divisor = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 11;
    while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
    total++; if (lat !== 33) begin bad++; $display("FAIL ignore_latency got=%0d exp=33", lat); end
    total++; if (quotient !== 32'd100) begin bad++; $display("FAIL ignore_quot got=%h exp=%h", quotient, 32'd100); end
    total++; if (remainder !== 32'd0) begin bad++; $display("FAIL ignore_rem got=%h exp=0", remainder); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] q, r;
    logic dz, bf, bl;
    int lat;
    run_div(1'b0, 32'd50, 32'd5, q, r, dz, lat, bf, bl);
    total++; if (q !== 32'd10 || r !== 32'd0) begin bad++; $display("FAIL b2b_first got q=%h r=%h exp q=%h r=0", q, r, 32'd10); end
    run_div(1'b1, 32'hFFFF_FFE7, 32'd4, q, r, dz, lat, bf, bl);
    total++; if (lat !== 33) begin bad++; $display("FAIL b2b_latency got=%0d exp=33", lat); end
    total++; if (bf !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b exp=1", bf); end
    total++; if (q !== 32'hFFFF_FFFA) begin bad++; $display("FAIL b2b_quot got=%h exp=%h", q, 32'hFFFF_FFFA); end
    total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL b2b_rem got=%h exp=%h", r, 32'hFFFF_FFFF); end
    @(posedge clk);
    #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL b2b_done_fall got=%b exp=0", done); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] q, r;
    logic dz, bf, bl, saw_done;
    int lat;
    start = 1'b1;
    is_signed = 1'b0;
    dividend = 32'h0000_FFFF;
    divisor = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    total++; if (quotient !== 32'd0 || remainder !== 32'd0 || busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
      bad++; $display("FAIL midreset_outputs got q=%h r=%h busy=%b done=%b dz=%b exp all zero",
                      quotient, remainder, busy, done, div_by_zero);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) saw_done = 1'b1;
    end
    total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL midreset_no_done got=%b exp=0", saw_done); end
    run_div(1'b0, 32'd9, 32'd3, q, r, dz, lat, bf, bl);
    total++; if (lat !== 33 || q !== 32'd3 || r !== 32'd0 || dz !== 1'b0) begin
      bad++; $display("FAIL midreset_recover got lat=%0d q=%h r=%h dz=%b exp lat=33 q=3 r=0 dz=0", lat, q, r, dz);
    end
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_directed();
    test_random();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
